// File: rtl/fwd_bypass_if.sv
// Decode-side bundle for the ID-stage operand bypass network: issue info, lookups and results.
// The master modport is the decode stage; the slave modport is the bypass network itself.
interface fwd_bypass_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned DEPTH   = 3,
   parameter int unsigned NUM_SRC = 2
);
   logic                        issue_valid;
   logic                        issue_we;
   logic [REG_AW-1:0]           issue_dst;
   logic                        issue_late;
   logic                        flush;
   logic [NUM_SRC*REG_AW-1:0]   src_addr;
   logic [NUM_SRC*DATA_W-1:0]   rf_data;
   logic [DEPTH*DATA_W-1:0]     stage_data;
   logic [NUM_SRC*DATA_W-1:0]   opnd_data;
   logic [NUM_SRC-1:0]          fwd_hit;
   logic                        stall;

   modport master (
      output issue_valid, issue_we, issue_dst, issue_late, flush,
      output src_addr, rf_data, stage_data,
      input  opnd_data, fwd_hit, stall
   );

   modport slave (
      input  issue_valid, issue_we, issue_dst, issue_late, flush,
      input  src_addr, rf_data, stage_data,
      output opnd_data, fwd_hit, stall
   );
endinterface

// File: rtl/fwd_bypass_net.sv
// ID-stage operand bypass: shift-register scoreboard of in-flight writes, youngest-match forwarding
// and decode stall on not-yet-ready producers. Define FWD_BYPASS_STATS_EN for usage counters.
module fwd_bypass_net #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned LATE_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   fwd_bypass_if.slave         bus
`ifdef FWD_BYPASS_STATS_EN
   ,
   output logic [31:0]         stat_fwd_cnt,
   output logic [31:0]         stat_stall_cnt
`endif
);

   // LATE_LAT == 0 still needs a 1-bit counter field to keep the struct legal.
   localparam int unsigned CntW = (LATE_LAT > 0) ? $clog2(LATE_LAT + 1) : 1;

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] dst;
      logic [CntW-1:0]   cnt;
   } entry_t;

   entry_t [DEPTH-1:0]         ent_q, ent_d;

   logic [NUM_SRC-1:0]         blocked;
   logic [NUM_SRC-1:0]         hit;
   logic [NUM_SRC*DATA_W-1:0]  opnd;
   logic                       stall;
   logic                       load_en;

   logic [REG_AW-1:0]          src   [NUM_SRC];
   logic                       found [NUM_SRC];
   logic                       rdy   [NUM_SRC];
   logic [DATA_W-1:0]          fwd_val [NUM_SRC];

   // Lookup: scan oldest to youngest so the youngest match overwrites the others.
   always_comb begin
      blocked = '0;
      hit     = '0;
      opnd    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src[i]     = bus.src_addr[i*REG_AW +: REG_AW];
         found[i]   = 1'b0;
         rdy[i]     = 1'b0;
         fwd_val[i] = '0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_q[k].vld && (ent_q[k].dst == src[i]) && (src[i] != '0)) begin
               found[i]   = 1'b1;
               rdy[i]     = (ent_q[k].cnt == '0);
               fwd_val[i] = bus.stage_data[k*DATA_W +: DATA_W];
            end
         end
         if (found[i] && rdy[i]) begin
            opnd[i*DATA_W +: DATA_W] = fwd_val[i];
            hit[i]                   = 1'b1;
         end else begin
            opnd[i*DATA_W +: DATA_W] = bus.rf_data[i*DATA_W +: DATA_W];
            blocked[i]               = found[i];
         end
      end
   end

   assign stall = bus.issue_valid && (|blocked);

   always_comb begin
      bus.opnd_data = opnd;
      bus.fwd_hit   = hit;
      bus.stall     = stall;
   end

   assign load_en = bus.issue_valid && bus.issue_we && !stall && !bus.flush &&
                    (bus.issue_dst != '0);

   // Stages past decode never stall; a stalled or non-writing issue becomes a bubble.
   always_comb begin
      ent_d = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         ent_d[k].vld = ent_q[k-1].vld && !bus.flush;
         ent_d[k].dst = ent_q[k-1].dst;
         ent_d[k].cnt = (ent_q[k-1].cnt == '0) ? '0 : ent_q[k-1].cnt - CntW'(1);
      end
      if (load_en) begin
         ent_d[0].vld = 1'b1;
         ent_d[0].dst = bus.issue_dst;
         ent_d[0].cnt = bus.issue_late ? CntW'(LATE_LAT) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

`ifdef FWD_BYPASS_STATS_EN
   logic [31:0] stat_fwd_q, stat_fwd_d;
   logic [31:0] stat_stall_q, stat_stall_d;
   logic [31:0] fwd_add;
   logic [32:0] fwd_sum;

   always_comb begin
      fwd_add = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         fwd_add = fwd_add + {31'd0, hit[i]};
      end
      fwd_sum    = {1'b0, stat_fwd_q} + {1'b0, fwd_add};
      stat_fwd_d = stat_fwd_q;
      if (bus.issue_valid && !stall) begin
         stat_fwd_d = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      end
      stat_stall_d = stat_stall_q;
      if (stall && (stat_stall_q != 32'hFFFF_FFFF)) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fwd_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_fwd_q   <= stat_fwd_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_fwd_cnt   = stat_fwd_q;
   assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Self-checking bench for fwd_bypass_net: directed scenarios then random traffic against an
// age-based model of in-flight writes.
module tb_fwd_bypass_net;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned DEPTH    = 3;
   localparam int unsigned NUM_SRC  = 2;
   localparam int unsigned LATE_LAT = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fwd_bypass_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC)) bus ();

`ifdef FWD_BYPASS_STATS_EN
   logic [31:0] stat_fwd_cnt, stat_stall_cnt;
`endif

   fwd_bypass_net #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .LATE_LAT(LATE_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FWD_BYPASS_STATS_EN
      ,
      .stat_fwd_cnt   (stat_fwd_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Model: slot k holds the write issued k+1 cycles ago; it is usable once k >= its latency.
   bit                m_vld  [DEPTH];
   logic [REG_AW-1:0] m_dst  [DEPTH];
   bit                m_late [DEPTH];
   longint unsigned   m_fwd, m_stall;

   logic [NUM_SRC*DATA_W-1:0] e_opnd;
   logic [NUM_SRC-1:0]        e_hit;
   logic                      e_stall;

   function automatic void model_clear();
      for (int k = 0; k < DEPTH; k++) begin
         m_vld[k] = 0; m_dst[k] = '0; m_late[k] = 0;
      end
      m_fwd = 0; m_stall = 0;
   endfunction

   function automatic void model_eval();
      e_opnd  = bus.rf_data;
      e_hit   = '0;
      e_stall = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         logic [REG_AW-1:0] s;
         int y;
         s = bus.src_addr[i*REG_AW +: REG_AW];
         y = -1;
         for (int k = 0; k < DEPTH; k++)
            if (y < 0 && m_vld[k] && m_dst[k] == s && s != 0) y = k;
         if (y >= 0) begin
            if (y >= (m_late[y] ? int'(LATE_LAT) : 0)) begin
               e_hit[i] = 1'b1;
               e_opnd[i*DATA_W +: DATA_W] = bus.stage_data[y*DATA_W +: DATA_W];
            end else if (bus.issue_valid) begin
               e_stall = 1'b1;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 after inputs are driven; compares at posedge+4.
   task automatic eval_chk(input string tag);
      #3;
      model_eval();
      chk({tag, " opnd"},  64'(bus.opnd_data), 64'(e_opnd));
      chk({tag, " hit"},   64'(bus.fwd_hit),   64'(e_hit));
      chk({tag, " stall"}, 64'(bus.stall),     64'(e_stall));
`ifdef FWD_BYPASS_STATS_EN
      chk({tag, " sfwd"},   64'(stat_fwd_cnt),   64'(m_fwd));
      chk({tag, " sstall"}, 64'(stat_stall_cnt), 64'(m_stall));
`endif
   endtask

   task automatic adv();
      bit load;
      if (bus.issue_valid && !e_stall) m_fwd += longint'($countones(e_hit));
      if (m_fwd > 64'hFFFF_FFFF) m_fwd = 64'hFFFF_FFFF;
      if (e_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
      load = bus.issue_valid && bus.issue_we && !e_stall && !bus.flush && bus.issue_dst != 0;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            m_vld[k]  = m_vld[k-1] && !bus.flush;
            m_dst[k]  = m_dst[k-1];
            m_late[k] = m_late[k-1];
         end
         m_vld[0] = load; m_dst[0] = bus.issue_dst; m_late[0] = bus.issue_late;
      end
      #1;
   endtask

   task automatic step(input string tag);
      eval_chk(tag);
      adv();
   endtask

   task automatic iss(input bit v, input bit we, input int dst, input bit late);
      bus.issue_valid = v; bus.issue_we = we;
      bus.issue_dst = REG_AW'(dst); bus.issue_late = late;
   endtask

   task automatic srcs(input int a0, input int a1);
      bus.src_addr = {REG_AW'(a1), REG_AW'(a0)};
   endtask

   task automatic rand_data();
      bus.rf_data    = {$urandom, $urandom};
      bus.stage_data = {$urandom, $urandom, $urandom};
   endtask

   initial begin
      model_clear();
      iss(0, 0, 0, 0); srcs(0, 0); bus.flush = 1'b0; rand_data();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fill the table with writers to r3, then reset mid-stream.
      iss(1, 1, 3, 0); step("pre_a");
      iss(1, 1, 3, 1); srcs(3, 3); rand_data(); step("pre_b");
      rst_n = 1'b0; #1;
      model_clear();
      eval_chk("rst_hold");
      chk("rst_hold stall0", 64'(bus.stall), 64'd0);
      chk("rst_hold rf", 64'(bus.opnd_data), 64'(bus.rf_data));
      adv();
      rst_n = 1'b1; rand_data();
      eval_chk("rst_post");
      chk("rst_post hit0", 64'(bus.fwd_hit), 64'd0);
      adv();

      // Forwarding and stall counting sequence.
      iss(1, 1, 8, 0); srcs(0, 0); step("add8");
      iss(1, 1, 10, 0); srcs(8, 8); bus.stage_data[31:0] = 32'h1234_5678; eval_chk("fwd8");
      chk("fwd8 data", 64'(bus.opnd_data[31:0]), 64'h1234_5678);
      chk("fwd8 hit", 64'(bus.fwd_hit), 64'd3);
      adv();
      iss(1, 0, 0, 0); srcs(10, 0); rand_data(); step("fwd10a");
      srcs(10, 0); rand_data(); step("fwd10b");
      iss(1, 1, 9, 1); srcs(0, 0); step("lw9");
      iss(1, 0, 0, 0); srcs(0, 9); eval_chk("lw9_use");
      chk("lw9 stall", 64'(bus.stall), 64'd1);
      adv();
      iss(0, 0, 0, 0); srcs(0, 9); bus.stage_data[63:32] = 32'hCAFE_0009; eval_chk("lw9_rdy");
      chk("lw9 fwd", 64'(bus.opnd_data[63:32]), 64'hCAFE_0009);
      chk("lw9 nostall", 64'(bus.stall), 64'd0);
      adv();
      iss(1, 1, 11, 1); srcs(0, 0); step("lw11");
      iss(1, 1, 12, 0); srcs(11, 0); step("lw11_use");
      iss(0, 0, 0, 0); srcs(0, 0); step("idle");
`ifdef FWD_BYPASS_STATS_EN
      #3;
      chk("stat fwd", 64'(stat_fwd_cnt), 64'd4);
      chk("stat stall", 64'(stat_stall_cnt), 64'd2);
      #1;
`endif
      // Two writers to r4: the younger one wins.
      iss(1, 1, 4, 0); step("w4a");
      iss(1, 1, 5, 0); step("w5");
      iss(1, 1, 4, 0); step("w4b");
      iss(1, 1, 0, 0); srcs(4, 0);
      bus.stage_data = {32'hC, 32'hB, 32'hA}; eval_chk("r4");
      chk("r4 young", 64'(bus.opnd_data[31:0]), 64'hA);
      adv();
      iss(0, 0, 0, 0); srcs(0, 0); rand_data(); eval_chk("r0");
      chk("r0 rf", 64'(bus.opnd_data), 64'(bus.rf_data));
      adv();

      // Flush overrides a stalled issue.
      iss(1, 1, 7, 1); step("lw7");
      iss(1, 1, 13, 0); srcs(7, 0); bus.flush = 1'b1; eval_chk("flush");
      chk("flush stall", 64'(bus.stall), 64'd1);
      adv();
      bus.flush = 1'b0; rand_data(); eval_chk("post_flush");
      chk("post_flush stall", 64'(bus.stall), 64'd0);
      chk("post_flush rf", 64'(bus.opnd_data[31:0]), 64'(bus.rf_data[31:0]));
      adv();

      // Random traffic on a small register window to provoke matches.
      for (int n = 0; n < 400; n++) begin
         iss($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
             $urandom_range(0, 7), $urandom_range(0, 9) < 3);
         srcs($urandom_range(0, 7), $urandom_range(0, 7));
         bus.flush = ($urandom_range(0, 99) < 4);
         rand_data();
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fwd_bypass_net.md
Name: fwd_bypass_net

Overview:
- Parametrised ID-stage operand bypass network; the next generation of the 3-way ID forwarding select.
- Tracks in-flight register writes in an internal shift-register scoreboard of DEPTH stages beyond decode.
- Supports NUM_SRC source operands, N-stage forwarding and load/multi-cycle results that become ready late.
- Produces forwarded operands plus a decode stall when the youngest producer's data is not ready yet.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- DEPTH, 3, tracked pipeline stages after decode (entry 0 = EX, DEPTH-1 = WB)
- NUM_SRC, 2, source operands looked up per cycle
- LATE_LAT, 1, extra stages before a late (load) result is usable; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode holds a valid instruction this cycle
- issue_we  in  1  instruction writes a register
- issue_dst  in  REG_AW  destination register
- issue_late  in  1  result ready LATE_LAT stages after normal (load/mul)
- flush  in  1  kill all in-flight entries (branch/exception)
- src_addr  in  NUM_SRC*REG_AW  source register addresses, operand i at [i*REG_AW +: REG_AW]
- rf_data  in  NUM_SRC*DATA_W  register-file read data per operand
- stage_data  in  DEPTH*DATA_W  result currently held in pipeline stage k, at [k*DATA_W +: DATA_W]
- opnd_data  out  NUM_SRC*DATA_W  selected operand values
- fwd_hit  out  NUM_SRC  operand i was taken from stage_data
- stall  out  1  decode must hold; a bubble is inserted into entry 0

Behaviour:
- Entry state per stage k: vld, dst[REG_AW], cnt[clog2(LATE_LAT+1)]. Entry is ready when cnt==0.
- All entries shift every cycle: e[k] <= e[k-1]. Stages beyond decode never stall.
- Entry 0 load condition: issue_valid && issue_we && !stall && !flush && issue_dst!=0.
  - When true: e[0] <= {1, issue_dst, issue_late ? LATE_LAT : 0}.
  - Otherwise: e[0] <= bubble (vld=0).
- Shift rule for cnt: cnt <= (cnt==0) ? 0 : cnt-1.
- flush: every vld clears at the next edge, including the entry being issued; it overrides issue. Stats still count the current cycle.
- Lookup is combinational from current state, per operand i. Match at k means vld && dst==src_addr[i] && src_addr[i]!=0.
  - The youngest match (lowest k) wins. Older matches are ignored even if they are ready.
  - Youngest match ready: opnd_data[i]=stage_data[k], fwd_hit[i]=1.
  - Youngest match not ready: opnd_data[i]=rf_data[i], fwd_hit[i]=0, operand is blocked.
  - No match, or src_addr==0: opnd_data[i]=rf_data[i], fwd_hit[i]=0.
- stall = issue_valid && (any operand blocked). stall must not depend on issue_we/issue_dst of the stalled instruction.
- The register file is write-before-read: an entry leaving stage DEPTH-1 is visible in rf_data the next cycle, so no lookup past the last entry is needed.
- Latency: zero-cycle combinational lookup. The scoreboard updates one cycle after issue.
- Reset (async, rst_n=0): all vld=0, cnt=0, stats=0. Resulting outputs: stall=0, fwd_hit=0, opnd_data=rf_data.
- Reset asserted mid-operation discards all in-flight entries immediately. The first cycle after release behaves as empty.
- Simultaneous stall and flush: flush wins; entries clear and stall deasserts the cycle after (table empty).
- Width rule: src_addr and dst are compared at the full REG_AW. There is no partial match.

Optional Feature:
- Macro: FWD_BYPASS_STATS_EN.
- Defined:
  - Adds outputs stat_fwd_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_fwd_cnt increments by popcount(fwd_hit) each cycle issue_valid && !stall.
  - stat_stall_cnt increments each cycle stall=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent, with no other behaviour change.

Test Plan:
- Reset with rst_n=0 mid-stream, src_addr={5'd3,5'd3}, entries active -> stall=0, fwd_hit=0, opnd_data=rf_data while reset and the cycle after release.
- Issue ADD dst=8 (late=0), next cycle src0=8, stage_data[0]=32'h1234_5678 -> fwd_hit[0]=1, opnd_data[0]=32'h1234_5678, stall=0.
- LW dst=9 (late=1, LATE_LAT=1), next cycle src1=9 -> stall=1 for exactly 1 cycle. Following cycle: fwd_hit[1]=1 with stage_data[1].
- Two writers to r4 at entries 0 and 2 (different stage_data 0xA, 0xC), src0=4 -> opnd_data[0]=0xA; src_addr=0 with a matching dst=0 issue -> no entry created, rf_data used.
- Load dst=7 pending with src0=7, flush=1 -> the next cycle has all entries invalid, stall=0, opnd_data[0]=rf_data[0].
- With FWD_BYPASS_STATS_EN: 3 forwarding cycles (one with both operands hit) plus 2 stall cycles -> stat_fwd_cnt=4, stat_stall_cnt=2.
